// File: rtl/key_event_pkg.sv
// Shared constants and types for the key-event front end.
// Scan codes, event-kind encoding and repeat FSM states.
// No logic; imported by the mapper and its FIFO.
package key_event_pkg;

  // PS/2 scan codes as reported by the decoder (bit 8 = extended prefix)
  localparam logic [8:0] SC_ESC       = 9'h076;
  localparam logic [8:0] SC_ENTER     = 9'h05A;
  localparam logic [8:0] SC_BACKSPACE = 9'h066;
  localparam logic [8:0] SC_SHIFT     = 9'h059;
  localparam logic [8:0] SC_A         = 9'h01C;
  localparam logic [8:0] SC_D         = 9'h023;

  typedef enum logic [1:0] {
    EVT_RELEASE = 2'd0,
    EVT_PRESS   = 2'd1,
    EVT_REPEAT  = 2'd2
  } evt_kind_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_DELAY  = 2'd1,
    R_REPEAT = 2'd2
  } rstate_e;

endpackage

// File: rtl/key_event_fifo.sv
// Ready/valid event FIFO with sticky overflow flag.
// Latency: a push is visible at the head on the next edge.
// Backpressure: full FIFO drops a push unless a pop happens in the same cycle.
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld_i,
  input  logic [W-1:0] push_dat_i,
  output logic         pop_vld_o,
  input  logic         pop_rdy_i,
  output logic [W-1:0] pop_dat_o,
  input  logic         clr_overflow_i,
  output logic         overflow_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         ovf_q;
  logic         empty, full, pop, accept, drop;

  // Occupancy flags and handshake decisions; extra pointer MSB tells full from empty
  always_comb begin
    empty  = (wr_q == rd_q);
    full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop    = !empty && pop_rdy_i;
    accept = push_vld_i && (!full || pop);
    drop   = push_vld_i && !accept;
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q[AW-1:0]] <= push_dat_i;
  end

  // Pointers and sticky overflow; a drop outranks a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) wr_q <= wr_q + 1'b1;
      if (pop)    rd_q <= rd_q + 1'b1;
      if (drop)                ovf_q <= 1'b1;
      else if (clr_overflow_i) ovf_q <= 1'b0;
    end
  end

  assign pop_vld_o  = !empty;
  assign pop_dat_o  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign overflow_o = ovf_q;

endmodule

// File: rtl/key_event_mapper.sv
// Maps decoder scan-code events to held levels, press/release/repeat pulses and a queued event stream.
// Latency: pulses 1 cycle after key_valid, queued event visible 2 cycles after key_valid.
// Backpressure: evt_ready stalls the queue; events arriving at a full queue are dropped and flag overflow.
module key_event_mapper
  import key_event_pkg::*;
#(
  parameter int                    NUM_KEYS      = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = {SC_SHIFT, SC_BACKSPACE, SC_ENTER, SC_ESC},
  parameter int                    REPEAT_DELAY  = 50_000_000,
  parameter int                    REPEAT_PERIOD = 10_000_000,
  parameter int                    FIFO_DEPTH    = 8,
  localparam int                   IDX_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [511:0]        key_down,
  input  logic [8:0]          last_change,
  input  logic                key_valid,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] repeat_pulse,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_idx,
  output logic [1:0]          evt_kind,
  output logic                overflow,
  input  logic                clr_overflow
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int EW      = IDX_W + 2;
  localparam logic [CW-1:0] DLY_LAST = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0] PER_LAST = CW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  logic [NUM_KEYS-1:0] held_q, press_q, rel_q, rep_q;
  logic                push_vld_q;
  logic [EW-1:0]       push_dat_q;
  rstate_e             st_q;
  logic [CW-1:0]       rcnt_q;
  logic [IDX_W-1:0]    rkey_q;

  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             press_ev, rel_ev, dec_ev, tgt_rel, tick_due, tick_fire;

  // Code lookup: scan downwards so the lowest matching index is the one kept
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[i*9 +: 9] == last_change) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Event classification and repeat-tick arbitration; decoder events own the FIFO write port
  always_comb begin
    press_ev  = key_valid && hit && key_down[last_change] && !held_q[hit_idx];
    rel_ev    = key_valid && hit && !key_down[last_change] && held_q[hit_idx];
    dec_ev    = press_ev || rel_ev;
    tgt_rel   = rel_ev && (hit_idx == rkey_q) && (st_q != R_IDLE);
    tick_due  = ((st_q == R_DELAY) && (rcnt_q == DLY_LAST)) ||
                ((st_q == R_REPEAT) && (rcnt_q == PER_LAST));
    tick_fire = tick_due && !dec_ev;
  end

  // Repeat FSM: a press retargets, a target release idles, a blocked tick holds rcnt for one more cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= R_IDLE;
      rcnt_q <= '0;
      rkey_q <= '0;
      rep_q  <= '0;
    end else begin
      rep_q <= '0;
      if (press_ev) begin
        rkey_q <= hit_idx;
        rcnt_q <= '0;
        st_q   <= (REPEAT_DELAY != 0) ? R_DELAY : R_IDLE;
      end else if (tgt_rel) begin
        st_q   <= R_IDLE;
        rcnt_q <= '0;
      end else if (tick_fire) begin
        st_q          <= R_REPEAT;
        rcnt_q        <= '0;
        rep_q[rkey_q] <= 1'b1;
      end else if (!tick_due && (st_q != R_IDLE)) begin
        rcnt_q <= rcnt_q + 1'b1;
      end
    end
  end

  // Held levels, edge pulses and the registered FIFO write request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q     <= '0;
      press_q    <= '0;
      rel_q      <= '0;
      push_vld_q <= 1'b0;
      push_dat_q <= '0;
    end else begin
      press_q    <= '0;
      rel_q      <= '0;
      push_vld_q <= dec_ev || tick_fire;
      if (press_ev) begin
        held_q[hit_idx]  <= 1'b1;
        press_q[hit_idx] <= 1'b1;
        push_dat_q       <= {hit_idx, EVT_PRESS};
      end else if (rel_ev) begin
        held_q[hit_idx]  <= 1'b0;
        rel_q[hit_idx]   <= 1'b1;
        push_dat_q       <= {hit_idx, EVT_RELEASE};
      end else if (tick_fire) begin
        push_dat_q       <= {rkey_q, EVT_REPEAT};
      end
    end
  end

  logic [EW-1:0] head_dat;

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk            (clk),
    .rst_n          (rst_n),
    .push_vld_i     (push_vld_q),
    .push_dat_i     (push_dat_q),
    .pop_vld_o      (evt_valid),
    .pop_rdy_i      (evt_ready),
    .pop_dat_o      (head_dat),
    .clr_overflow_i (clr_overflow),
    .overflow_o     (overflow)
  );

  assign held          = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign repeat_pulse  = rep_q;
  assign evt_idx       = head_dat[EW-1:2];
  assign evt_kind      = head_dat[1:0];

endmodule

// File: doc/key_event_mapper.md
# key_event_mapper

Parametrised key-event front end between `KeyboardDecoder` and game logic. It maps up to `NUM_KEYS` configurable PS/2 scan codes to logical key indices. For each mapped key it produces registered `held` levels and one-cycle press, release and auto-repeat pulses. Every event is also queued in a small FIFO that a ready/valid consumer can drain across frames.

## Interface
- `NUM_KEYS`, default 4: number of mapped keys; legal range 1..16.
- `KEY_CODES`, default {SHIFT, BACKSPACE, ENTER, ESC}: packed `NUM_KEYS*9` bits; slice i is the 9-bit code for index i.
- `REPEAT_DELAY`, default 50_000_000: cycles from press to the first repeat; 0 disables repeat.
- `REPEAT_PERIOD`, default 10_000_000: cycles between repeats; must be ≥1.
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, ≥2.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `key_down` in 512: decoder key-state vector.
- `last_change` in 9: decoder most-recent scan code.
- `key_valid` in 1: decoder one-cycle event strobe.
- `held` out NUM_KEYS: mapped key currently down.
- `press_pulse` out NUM_KEYS: one cycle per new press.
- `release_pulse` out NUM_KEYS: one cycle per release.
- `repeat_pulse` out NUM_KEYS: one cycle per auto-repeat tick.
- `evt_valid` out 1: FIFO head valid.
- `evt_ready` in 1: consumer accepts the head.
- `evt_idx` out IDX_W: head key index, where IDX_W = max(1, clog2(NUM_KEYS)).
- `evt_kind` out 2: head kind; 0=release, 1=press, 2=repeat.
- `overflow` out 1: sticky, set when an event is dropped.
- `clr_overflow` in 1: synchronous clear of `overflow`.

## Operation
- **Lookup.** On a `key_valid` cycle, `last_change` is compared with every `KEY_CODES` slice. The lowest matching index wins. No match means the strobe is ignored.
- **Press.** `key_down[last_change]`=1 with `held[i]`=0: set `held[i]`, pulse `press_pulse[i]`, push {i, press}, and retarget repeat to i.
- **Keyboard typematic.** `key_down[last_change]`=1 with `held[i]`=1: ignored entirely. Repeat timing comes only from this block.
- **Release.** `key_down[last_change]`=0 with `held[i]`=1: clear `held[i]`, pulse `release_pulse[i]`, push {i, release}. If i is the repeat target, the repeat FSM goes to R_IDLE.
- **Spurious release.** `key_down[last_change]`=0 with `held[i]`=0: ignored.
- **Repeat FSM.**
  - Holds a single target, `rkey`, and counter `rcnt`. Width of `rcnt` is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
  - R_IDLE: left on a press to R_DELAY with `rcnt`=0. If REPEAT_DELAY=0 the FSM never leaves R_IDLE.
  - R_DELAY: `rcnt` increments each cycle. At `rcnt`=REPEAT_DELAY-1 it emits a tick, clears `rcnt`, and moves to R_REPEAT.
  - R_REPEAT: emits a tick at `rcnt`=REPEAT_PERIOD-1, then clears `rcnt`.
  - A press of another key restarts R_DELAY on the new target. Releasing a non-target key has no effect on the FSM.
- **Tick.** Pulses `repeat_pulse[rkey]` and pushes {rkey, repeat}.
- **Write arbitration.** The FIFO takes one push per cycle. A decoder event beats a tick in the same cycle. The losing tick is deferred: `rcnt` holds at its terminal value and the tick fires the next cycle, pulse included.
- **FIFO full.**
  - A push is accepted if the FIFO is not full, or if a pop (`evt_valid`&&`evt_ready`) occurs in the same cycle.
  - Otherwise the event is dropped and `overflow` is set. The `held` and pulse outputs still update.
  - `clr_overflow` and a drop in the same cycle leave `overflow`=1.
- **Pointers.** Head and tail pointers use log2(FIFO_DEPTH)+1 bits and wrap naturally. Full means MSBs differ and LSBs are equal.

## Timing
- **Reset.** All outputs are 0 asynchronously. The FSM is in R_IDLE, FIFO is empty, `overflow`=0.
- **Pulse latency.** `held` and `press_pulse`/`release_pulse` are registered and change on the edge after `key_valid` (1 cycle). Repeat pulses are registered the same way.
- **Event latency.** A pushed event shows on `evt_valid` and head outputs on the next edge, so 2 cycles after `key_valid`.
- **FIFO head.** The head is stable while `evt_valid`=1 and `evt_ready`=0. A pop advances the head on the next edge.
- **Throughput.** Full throughput: one push and one pop per cycle.
- **First repeat.** With a press registered at cycle T, the first repeat pulse is at T+REPEAT_DELAY. Subsequent pulses are every REPEAT_PERIOD cycles, unless deferred.
- **Reset mid-operation.** Clears everything immediately, including held keys and queued events. No release events are generated.

## Structure
- **Package `key_event_pkg`.** Holds:
  - scan-code constants ESC 9'h076, ENTER 9'h05A, BACKSPACE 9'h066, SHIFT 9'h059, A 9'h01C, D 9'h023;
  - the `evt_kind` enum (RELEASE, PRESS, REPEAT);
  - the repeat FSM state enum.
- **Sub-module `key_event_fifo`.** Parametrised synchronous ready/valid FIFO with overflow flag. The top level holds the lookup, `held` registers and repeat FSM.

## Test plan
Bench configuration for all scenarios: default `KEY_CODES`, REPEAT_DELAY=10, REPEAT_PERIOD=4, FIFO_DEPTH=4.

1. **Press and release ENTER.** `key_valid` with code 0x05A, `key_down`=1 → `held[1]`=1 and `press_pulse[1]` for 1 cycle; FIFO head {1, PRESS}. Then the same code with `key_down`=0 → `release_pulse[1]`, event {1, RELEASE}.
2. **Auto-repeat.** Hold ESC for 30 cycles → repeat pulses on index 0 at T+10, T+14, T+18, T+22, T+26. Releasing at T+20 → no further repeat pulses.
3. **Retarget and priority.** Press ESC, press SHIFT 5 cycles later, then send a decoder event on the exact tick cycle → repeat target becomes index 3; the tick is deferred one cycle; FIFO order is {0,P}, {3,P}, event, {3,R}.
4. **Overflow.** `evt_ready`=0, then 5 presses/releases → 4 queued, `overflow`=1. Pulse `clr_overflow` → 0. Push and pop together while full → accepted, occupancy stays 4.
5. **Ignored inputs.** Unmapped code 0x01C, and repeated make of an already-held key → no pulses, no FIFO push.
6. **Reset mid-operation.** Assert `rst_n`=0 with 3 events queued and key 2 held → all outputs 0 immediately, `evt_valid`=0, no release emitted after reset.
